conv_3_sdiv_sdiv_24_8_seq: RTL

- Iterative signed divider: the inverse operation of the conv_3 16x8 signed multiplier.
- Takes a 24-bit signed dividend (a conv_3 product or accumulator value) and an 8-bit signed divisor.
- Returns a 16-bit signed saturated quotient and an 8-bit signed remainder.
- Sits in the conv_3 post-processing path for average-pooling and rescale, behind valid/ready handshakes.

---
 rtl/conv_3_sdiv_sdiv_24_8_seq.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_3_sdiv_sdiv_24_8_seq.sv
// Iterative restoring signed divider, 24-bit dividend by 8-bit divisor, for the conv_3
// post-processing path. Truncating quotient saturated to 16 bits, remainder follows the dividend.
module conv_3_sdiv_sdiv_24_8_seq #(
  parameter int unsigned ID         = 32'd1,
  parameter int unsigned din0_WIDTH = 32'd24,
  parameter int unsigned din1_WIDTH = 32'd8,
  parameter int unsigned dout_WIDTH = 32'd16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz
);

  if (din0_WIDTH != 32'd24 || din1_WIDTH != 32'd8 || dout_WIDTH != 32'd16) begin : g_width_guard
    $error("conv_3_sdiv_sdiv_24_8_seq instance %0d: widths are fixed at 24/8/16", ID);
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [23:0] r_dvd;
  logic [7:0]  r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dvs_zero;
  logic [7:0]  r_prem;
  logic [23:0] r_q;

  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_quot;
  logic [7:0]  r_rem;
  logic        r_ovf;
  logic        r_dbz;

  logic        w_in_ready_nxt;
  logic        w_out_valid_nxt;
  logic [15:0] w_quot_fix;
  logic [7:0]  w_rem_fix;
  logic        w_ovf_fix;
  logic        w_dbz_fix;

  // Magnitudes as unsigned: -2^23 and -128 map to 2^23 and 128, which still fit.
  logic [23:0] w_din0_abs;
  logic [7:0]  w_din1_abs;
  logic [8:0]  w_shift;
  logic        w_ge;
  logic [7:0]  w_diff;

  assign w_din0_abs = din0[23] ? (24'd0 - din0) : din0;
  assign w_din1_abs = din1[7]  ? (8'd0 - din1)  : din1;
  assign w_shift    = {r_prem, r_dvd[23]};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_diff     = w_shift[7:0] - r_dvs;

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_nxt = S_CALC;
        else          w_state_nxt = S_IDLE;
      end
      S_CALC: begin
        if (r_cnt == 5'd23) w_state_nxt = S_FIX;
        else                w_state_nxt = S_CALC;
      end
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: begin
        if (out_ready) w_state_nxt = S_IDLE;
        else           w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags follow the state being entered so they can be registered
  always_comb begin
    w_in_ready_nxt  = (w_state_nxt == S_IDLE);
    w_out_valid_nxt = (w_state_nxt == S_DONE);
  end

  // Sign application and saturation of the unsigned quotient/remainder
  always_comb begin
    w_quot_fix = 16'd0;
    w_rem_fix  = 8'd0;
    w_ovf_fix  = 1'b0;
    w_dbz_fix  = 1'b0;
    if (r_dvs_zero) begin
      w_dbz_fix  = 1'b1;
      w_quot_fix = r_neg_r ? 16'h8000 : 16'h7FFF;
    end else begin
      w_rem_fix = r_neg_r ? (8'd0 - r_prem) : r_prem;
      if (r_neg_q) begin
        if (r_q > 24'd32768) begin
          w_quot_fix = 16'h8000;
          w_ovf_fix  = 1'b1;
        end else begin
          w_quot_fix = 16'd0 - r_q[15:0];
        end
      end else begin
        if (r_q > 24'd32767) begin
          w_quot_fix = 16'h7FFF;
          w_ovf_fix  = 1'b1;
        end else begin
          w_quot_fix = r_q[15:0];
        end
      end
    end
  end

  // Operand capture and one restoring step per CALC cycle
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cnt      <= 5'd0;
      r_dvd      <= 24'd0;
      r_dvs      <= 8'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dvs_zero <= 1'b0;
      r_prem     <= 8'd0;
      r_q        <= 24'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dvd      <= w_din0_abs;
            r_dvs      <= w_din1_abs;
            r_neg_q    <= din0[23] ^ din1[7];
            r_neg_r    <= din0[23];
            r_dvs_zero <= (din1 == 8'd0);
            r_prem     <= 8'd0;
            r_q        <= 24'd0;
            r_cnt      <= 5'd0;
          end
        end
        S_CALC: begin
          r_dvd  <= {r_dvd[22:0], 1'b0};
          r_prem <= w_ge ? w_diff : w_shift[7:0];
          r_q    <= {r_q[22:0], w_ge};
          r_cnt  <= r_cnt + 5'd1;
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Registered outputs; results load only in FIX and hold through DONE
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= 16'd0;
      r_rem       <= 8'd0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (r_state == S_FIX) begin
        r_quot <= w_quot_fix;
        r_rem  <= w_rem_fix;
        r_ovf  <= w_ovf_fix;
        r_dbz  <= w_dbz_fix;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quot      = r_quot;
  assign rem       = r_rem;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz;

endmodule
